// File: rtl/neuron_layer_sequencer.sv
// rtl/neuron_layer_sequencer.sv - time-multiplexes one singleNeuron across a fully connected layer
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, in_vec     pass request pulse and layer input vector (sampled on accepted start)
//   wAddr, wRd, wData synchronous weight ROM: row address, read strobe, row data (next cycle)
//   nRst, nStart      reset and start pulse to the neuron; shiftEn is constant 0
//   nInVec, nWVec     latched input vector and weight row driven to the neuron
//   nOut, nReady      neuron result and level-valid flag
//   oWe, oAddr, oData layer output buffer write port
//   busy, done, err   pass in progress, end-of-pass pulse, sticky watchdog timeout
module neuron_layer_sequencer #(
    parameter int N       = 4,
    parameter int M       = 10,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255,
    parameter int AW      = $clog2(M)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*DW-1:0] in_vec,
    output logic [AW-1:0]   wAddr,
    output logic            wRd,
    input  logic [N*DW-1:0] wData,
    output logic            nRst,
    output logic            nStart,
    output logic            shiftEn,
    output logic [N*DW-1:0] nInVec,
    output logic [N*DW-1:0] nWVec,
    input  logic [DW-1:0]   nOut,
    input  logic            nReady,
    output logic            oWe,
    output logic [AW-1:0]   oAddr,
    output logic [DW-1:0]   oData,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int WW = $clog2(TIMEOUT + 1);
    // wd holds the number of RUN cycles already completed, so the TIMEOUT-th
    // RUN cycle is the last one that may still accept nReady.
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(M - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, CLR, FIRE, RUN, STORE, DONE
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   index;
    logic [N*DW-1:0] in_lat;
    logic [N*DW-1:0] w_lat;
    logic [DW-1:0]   result;
    logic [WW-1:0]   wd;
    logic            err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = CLR;
            CLR:     state_nxt = FIRE;
            FIRE:    state_nxt = RUN;
            RUN:     if (nReady || wd == WD_LAST) state_nxt = STORE;
            STORE:   state_nxt = (index == IDX_LAST) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index  <= '0;
            in_lat <= '0;
            w_lat  <= '0;
            result <= '0;
            wd     <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        in_lat <= in_vec;
                        index  <= '0;
                        err_q  <= 1'b0;
                    end
                end
                WAIT: w_lat <= wData;
                FIRE: wd <= '0;
                RUN: begin
                    wd <= wd + WW'(1);
                    // A ready in the final watchdog cycle still counts as a result.
                    if (nReady) begin
                        result <= nOut;
                    end else if (wd == WD_LAST) begin
                        err_q  <= 1'b1;
                        result <= '0;
                    end
                end
                STORE: begin
                    if (index != IDX_LAST) index <= index + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Neuron is held in reset while idle and for one CLR cycle per neuron so a
    // stale nReady from the previous neuron cannot be mistaken for a result.
    assign nRst    = (state == IDLE) || (state == CLR);
    assign nStart  = (state == FIRE);
    assign shiftEn = 1'b0;
    assign wRd     = (state == FETCH);
    assign wAddr   = index;
    assign nInVec  = in_lat;
    assign nWVec   = w_lat;
    assign oWe     = (state == STORE);
    assign oAddr   = index;
    assign oData   = result;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = err_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb/tb_neuron_layer_sequencer.sv - self-checking bench for neuron_layer_sequencer
module tb_neuron_layer_sequencer;

    localparam int N = 4, M = 3, DW = 8, TMO = 8, AW = 2;

    logic            clk = 0;
    logic            rst = 1;
    logic            start = 0;
    logic [N*DW-1:0] in_vec = '0;
    logic [AW-1:0]   wAddr;
    logic            wRd;
    logic [N*DW-1:0] wData = '0;
    logic            nRst, nStart, shiftEn;
    logic [N*DW-1:0] nInVec, nWVec;
    logic [DW-1:0]   nOut;
    logic            nReady;
    logic            oWe;
    logic [AW-1:0]   oAddr;
    logic [DW-1:0]   oData;
    logic            busy, done, err;

    neuron_layer_sequencer #(.N(N), .M(M), .DW(DW), .TIMEOUT(TMO), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
        .wAddr(wAddr), .wRd(wRd), .wData(wData),
        .nRst(nRst), .nStart(nStart), .shiftEn(shiftEn),
        .nInVec(nInVec), .nWVec(nWVec), .nOut(nOut), .nReady(nReady),
        .oWe(oWe), .oAddr(oAddr), .oData(oData),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] rom [3];
    initial begin
        rom[0] = 32'hEB088AEE;
        rom[1] = 32'hC821A746;
        rom[2] = 32'h7CE0560F;
    end

    always @(posedge clk) if (wRd) wData <= (wAddr < 2'd3) ? rom[wAddr] : 32'h0;

    // Behavioural neuron: readies dly cycles after nStart (dly 0 = never) and
    // keeps nReady high until its next reset, modelling a stale ready.
    int   cur_dly [3];
    logic [7:0] cur_res [3];
    logic active = 0;
    int   ncnt = 0;
    int   nidx;

    always @(posedge clk) begin
        if (nRst) begin
            active <= 0;
            ncnt   <= 0;
        end else if (nStart) begin
            active <= 1;
            ncnt   <= 1;
        end else if (active) begin
            ncnt <= ncnt + 1;
        end
    end

    always_comb begin
        nidx = 0;
        for (int i = 0; i < 3; i++) if (rom[i] == nWVec) nidx = i;
        nOut   = cur_res[nidx];
        nReady = active && (cur_dly[nidx] != 0) && (ncnt >= cur_dly[nidx]);
    end

    typedef struct {
        int addr;
        int data;
        int c;
    } wr_t;
    wr_t wq[$];
    int  nstarts = 0;
    int  viol = 0;
    logic fired = 0;

    always @(negedge clk) begin
        if (oWe) begin
            wq.push_back('{int'(oAddr), int'(oData), cyc});
            if (!fired) viol++;
            fired = 0;
        end
        if (nStart) begin
            nstarts++;
            fired = 1;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] in;
        int          dly [3];
        logic [7:0]  res [3];
        logic [7:0]  exp_dat [3];
        logic        exp_err;
        int          exp_lat;
        int          poke;
    } vec_t;

    vec_t vecs [4];
    logic prev_err = 0;

    task automatic run_pass(input vec_t v);
        int s, n, off, k, ec;
        logic got;
        for (int i = 0; i < 3; i++) begin
            cur_dly[i] = v.dly[i];
            cur_res[i] = v.res[i];
        end
        wq.delete();
        @(negedge clk);
        check("err_before_start", err, prev_err);
        in_vec = v.in;
        start  = 1;
        s      = cyc;
        n      = 0;
        got    = 0;
        while (n < 300 && !got) begin
            @(negedge clk);
            n++;
            start  = 0;
            in_vec = ~v.in;
            if (n == 1) begin
                check("busy_after_start", busy, 1);
                check("err_cleared", err, 0);
            end
            if (done) got = 1;
            else if (v.poke != 0 && n == v.poke) begin
                start  = 1;
                in_vec = 32'hDEADBEEF;
            end
        end
        check("done_seen", got, 1);
        check("latency", cyc - s, v.exp_lat);
        check("err_end", err, v.exp_err);
        if (v.poke != 0) start = 1;
        @(negedge clk);
        start = 0;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("ninvec_latched", nInVec, v.in);
        check("write_count", wq.size(), 3);
        off = 0;
        for (int i = 0; i < 3; i++) begin
            k  = (v.dly[i] == 0) ? TMO : v.dly[i];
            ec = s + off + 5 + k;
            off += 5 + k;
            if (i < wq.size()) begin
                check("oaddr", wq[i].addr, i);
                check("odata", wq[i].data, v.exp_dat[i]);
                check("write_cycle", wq[i].c, ec);
            end
        end
        check("model_latency", v.exp_lat, off + 1);
        prev_err = v.exp_err;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nRst"}, nRst, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_oWe"}, oWe, 0);
        check({tag, "_wRd"}, wRd, 0);
        check({tag, "_nStart"}, nStart, 0);
        check({tag, "_shiftEn"}, shiftEn, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_nInVec"}, nInVec, 0);
        check({tag, "_nWVec"}, nWVec, 0);
        check({tag, "_oAddr"}, oAddr, 0);
    endtask

    initial begin
        int n, base;
        vecs[0] = '{32'h01CD1613, '{6, 6, 6}, '{8'h11, 8'h22, 8'h33}, '{8'h11, 8'h22, 8'h33}, 1'b0, 34, 0};
        vecs[1] = '{32'h01AABBCC, '{6, 0, 6}, '{8'h44, 8'h55, 8'h66}, '{8'h44, 8'h00, 8'h66}, 1'b1, 36, 0};
        vecs[2] = '{32'h01020304, '{8, 8, 8}, '{8'hA5, 8'h5A, 8'hFF}, '{8'hA5, 8'h5A, 8'hFF}, 1'b0, 40, 0};
        vecs[3] = '{32'h01112233, '{3, 5, 1}, '{8'h01, 8'h80, 8'h7F}, '{8'h01, 8'h80, 8'h7F}, 1'b0, 25, 7};
        for (int i = 0; i < 3; i++) begin
            cur_dly[i] = 6;
            cur_res[i] = 8'h00;
        end

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;

        for (int i = 0; i < 4; i++) run_pass(vecs[i]);

        // Reset while the second neuron is running.
        for (int i = 0; i < 3; i++) cur_dly[i] = 6;
        base = nstarts;
        @(negedge clk);
        in_vec = 32'h01FFEEDD;
        start  = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (nstarts < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_neuron1", nstarts, base + 2);
        repeat (2) @(negedge clk);
        check("in_run_busy", busy, 1);
        rst = 1;
        #1;
        check_reset_outputs("midrun");
        @(negedge clk);
        rst = 0;
        prev_err = 0;
        run_pass(vecs[0]);

        check("no_store_before_fire", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
Time-multiplexes one singleNeuron datapath across all neurons of a fully connected layer.
- Latches the layer input vector on start.
- Fetches each neuron's packed weight row from a synchronous weight ROM.
- Resets and starts the neuron, waits for its ready, then writes the 8-bit result into the layer output buffer.
- Sits between the top-level network controller and one singleNeuron instance; a watchdog flags a neuron that never completes.

Parameters:
N, 4, inputs per neuron including bias lane (most significant byte of in_vec carries constant 1)
M, 10, neurons in the layer
DW, 8, bits per input/weight lane
TIMEOUT, 255, max cycles to wait for nReady before aborting
AW, $clog2(M), weight/output address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse, begins a layer pass; ignored while busy=1
in_vec  in  N*DW  layer input vector, sampled on accepted start
wAddr  out  AW  weight ROM row address
wRd  out  1  weight ROM read strobe; data valid on wData the following cycle
wData  in  N*DW  weight row from ROM
nRst  out  1  reset to singleNeuron
nStart  out  1  start pulse to singleNeuron
shiftEn  out  1  to singleNeuron; tied 0
nInVec  out  N*DW  input vector to singleNeuron (latched copy)
nWVec  out  N*DW  weight row to singleNeuron (latched)
nOut  in  DW  singleNeuron result
nReady  in  1  singleNeuron result valid (level)
oWe  out  1  output buffer write strobe
oAddr  out  AW  output buffer address
oData  out  DW  output buffer data
busy  out  1  pass in progress
done  out  1  one-cycle pulse at pass end
err  out  1  sticky timeout flag; cleared by next accepted start or rst

Behaviour:
- Reset (async, immediate, any state, including mid-pass): state=IDLE, index=0.
  - All outputs 0, except nRst=1 (neuron held in reset while idle).
  - Latched vectors 0, err=0, watchdog=0.
- IDLE: nRst=1. On start=1: latch in_vec, index=0, err=0, busy=1 -> FETCH.
- FETCH (1 cycle): wRd=1, wAddr=index -> WAIT.
- WAIT (1 cycle): capture wData into nWVec at cycle end -> CLR.
- CLR (1 cycle): nRst=1 to clear the neuron's stale ready/accumulator -> FIRE.
- FIRE (1 cycle): nRst=0, nStart=1; watchdog=0 -> RUN.
- RUN: nRst=0, nStart=0, watchdog increments each cycle.
  - If nReady=1: capture nOut -> STORE.
  - Else if watchdog==TIMEOUT: err=1, write 8'h00 at index -> STORE.
  - nReady and timeout in the same cycle: nReady wins, err stays 0.
- STORE (1 cycle): oWe=1, oAddr=index, oData=captured result.
  - If index==M-1 -> DONE; else index+1 -> FETCH.
  - index never wraps past M-1.
- DONE (1 cycle): done=1, busy=0 at next edge -> IDLE.
- A timeout does not abort the pass; remaining neurons are still processed.
- Latency per neuron: 5 + k cycles, where k = RUN cycles up to and including the cycle nReady is sampled high.
- Pass latency: M*(5+k) + 1 cycles from start to done.
- busy=1 from the cycle after an accepted start through the DONE cycle.
- start while busy=1 (including the DONE cycle) is ignored; in_vec is not re-sampled.
- shiftEn is constant 0.
- oData is nOut passed unmodified; no sign or width changes.
- oWe asserts exactly once per neuron, in strictly ascending oAddr order.

Test Plan:
- Basic pass, N=4, M=3:
  - Stimulus: in_vec=32'h01CD1613; ROM rows 32'hEB088AEE, 32'hC821A746, 32'h7CE0560F; behavioural neuron stub asserts nReady 6 cycles after nStart with nOut = 8'h11, 8'h22, 8'h33.
  - Required: oWe at oAddr 0,1,2 with those values; done one cycle after the last STORE; busy low after; err=0; 3*(5+6)+1 = 34 cycles start-to-done.
- Stale ready:
  - Stimulus: stub holds nReady=1 until nRst.
  - Required: no STORE occurs before nStart; each result is captured only after CLR/FIRE.
- Timeout, TIMEOUT=8:
  - Stimulus: stub never readies neuron 1.
  - Required: err=1 after 8 RUN cycles; oData=8'h00 at oAddr 1; neuron 2 still processed; done pulses; err stays 1 until the next start.
- Start while busy:
  - Stimulus: pulse start mid-pass with a different in_vec.
  - Required: no restart; nInVec unchanged; exactly M writes.
- Reset mid-RUN (index=1):
  - Stimulus: assert rst.
  - Required: outputs to reset values in the same cycle; after release, start runs a full fresh pass from oAddr 0.
- Boundary, nReady coinciding with watchdog==TIMEOUT:
  - Required: result stored; err=0.
